// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for the single mmu request port: fixed priority to master 0,
// starvation-limited for master 1. Optional ARB_STATS_EN adds grant statistics counters.
module mem_port_arbiter #(
  parameter int unsigned MAX_WAIT = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  m_re,
  input  logic [1:0]  m_we,
  input  logic [31:0] m_addr [2],
  input  logic [31:0] m_wd [2],
  input  logic [1:0]  m_rd_unit [2],
  input  logic [1:0]  m_wd_unit [2],
  output logic [1:0]  m_gnt,
  output logic [1:0]  m_err,
  output logic [1:0]  m_rvalid,
  output logic [31:0] m_rd,
  output logic        mem_re,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  output logic [1:0]  mem_rd_unit,
  output logic [1:0]  mem_wd_unit,
  input  logic [31:0] mem_rd,
  input  logic        access_fault,
  input  logic        addr_misaligned
`ifdef ARB_STATS_EN
  ,
  output logic [31:0] stat_gnt0,
  output logic [31:0] stat_gnt1,
  output logic [31:0] stat_force
`endif
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  logic [1:0]       req;
  logic             force_win;
  logic             gnt_0;
  logic             gnt_1;
  logic             fault;
  logic             rd_issue;
  logic [CNT_W-1:0] wait_cnt;
  logic             rd_pend;
  logic             rd_owner;

  // Grant decision; everything is held off while reset is low.
  always_comb begin
    req       = m_re | m_we;
    force_win = reset & req[1] & (wait_cnt == MAX_CNT);
    gnt_1     = reset & req[1] & (~req[0] | force_win);
    gnt_0     = reset & req[0] & ~gnt_1;
    fault     = access_fault | addr_misaligned;
    m_gnt     = {gnt_1, gnt_0};
    m_err     = {gnt_1 & fault, gnt_0 & fault};
    rd_issue  = (gnt_0 & m_re[0] & ~fault) | (gnt_1 & m_re[1] & ~fault);
  end

  // Request mux onto the mmu port; all-zero when idle.
  always_comb begin
    mem_re      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = 32'h0;
    mem_wd      = 32'h0;
    mem_rd_unit = 2'b00;
    mem_wd_unit = 2'b00;
    if (gnt_0 | gnt_1) begin
      mem_re      = m_re[gnt_1];
      mem_we      = m_we[gnt_1];
      mem_addr    = m_addr[gnt_1];
      mem_wd      = m_wd[gnt_1];
      mem_rd_unit = m_rd_unit[gnt_1];
      mem_wd_unit = m_wd_unit[gnt_1];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_cnt <= '0;
      rd_pend  <= 1'b0;
      rd_owner <= 1'b0;
    end else begin
      if (gnt_1 || !req[1]) begin
        wait_cnt <= '0;
      end else if (wait_cnt != MAX_CNT) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
      rd_pend  <= rd_issue;
      rd_owner <= gnt_1;
    end
  end

  // Read return; a pending return is suppressed while reset is held low.
  always_comb begin
    m_rvalid = {rd_pend & rd_owner, rd_pend & ~rd_owner} & {2{reset}};
    m_rd     = (|m_rvalid) ? mem_rd : 32'h0;
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      stat_gnt0  <= 32'h0;
      stat_gnt1  <= 32'h0;
      stat_force <= 32'h0;
    end else begin
      if (gnt_0)     stat_gnt0  <= stat_gnt0 + 32'd1;
      if (gnt_1)     stat_gnt1  <= stat_gnt1 + 32'd1;
      if (force_win) stat_force <= stat_force + 32'd1;
    end
  end
`endif

endmodule
